// File: rtl/aes_key_loader.sv
// AES key loader: assembles 128/192/256-bit keys from a 32-bit word stream,
// fires the key-expansion start pulse and tracks the core's key-ready level.
module aes_key_loader #(
    parameter int WORD_W      = 32,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              clk,
    input  logic              resetH,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    input  logic [1:0]        s_mode,
    output logic              kb_start,
    output logic [1:0]        kb_key_mode,
    output logic [255:0]      kb_key,
    input  logic              kb_key_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int KEY_W = 256;
    localparam int TW    = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE, LOAD, START, WAIT_LO, WAIT_HI
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       word_cnt_q, word_cnt_d;
    logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [1:0]       mode_q, mode_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             xfer;
    logic [3:0]       nw;
    logic [3:0]       cnt_inc;
    logic [TW-1:0]    tmo_inc;
    logic [7:0]       shamt;
    logic [KEY_W-1:0] word_ext;

    assign s_ready     = (state_q == IDLE) || (state_q == LOAD);
    assign busy        = (state_q != IDLE);
    assign kb_start    = (state_q == START);
    assign kb_key      = key_q;
    assign kb_key_mode = mode_q;
    assign done        = done_q;
    assign err         = err_q;

    assign xfer     = s_valid && s_ready;
    assign cnt_inc  = word_cnt_q + 4'd1;
    assign tmo_inc  = tmo_cnt_q + 1'b1;
    assign shamt    = {word_cnt_q[2:0], 5'b0};
    assign word_ext = {s_data, {(KEY_W - WORD_W){1'b0}}};

    always_comb begin
        nw = 4'd4;
        case (mode_q)
            2'b01:   nw = 4'd6;
            2'b10:   nw = 4'd8;
            default: nw = 4'd4;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        key_d      = key_q;
        mode_d     = mode_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (s_mode == 2'b11) begin
                        err_d = 1'b1;
                    end else begin
                        mode_d     = s_mode;
                        key_d      = word_ext;
                        word_cnt_d = 4'd1;
                        state_d    = LOAD;
                    end
                end
            end
            LOAD: begin
                // Key is cleared on the first word, so OR-ing places each word.
                if (xfer) begin
                    key_d      = key_q | (word_ext >> shamt);
                    word_cnt_d = cnt_inc;
                    if (cnt_inc == nw) state_d = START;
                end
            end
            START: begin
                tmo_cnt_d = '0;
                state_d   = WAIT_LO;
            end
            WAIT_LO: begin
                tmo_cnt_d = tmo_inc;
                if (tmo_inc == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (!kb_key_ready) begin
                    state_d = WAIT_HI;
                end
            end
            WAIT_HI: begin
                tmo_cnt_d = tmo_inc;
                if (kb_key_ready) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (tmo_inc == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetH) begin
            state_q    <= IDLE;
            word_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            key_q      <= '0;
            mode_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            key_q      <= key_d;
            mode_q     <= mode_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end
endmodule

// File: tb/tb_aes_key_loader.sv
// Scoreboard bench for aes_key_loader: directed loads push expected
// start/done/err events; a negedge monitor pops and compares them.
module tb_aes_key_loader;
    localparam int TMO = 4096;

    logic         clk = 1'b0;
    logic         resetH = 1'b1;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [31:0]  s_data = '0;
    logic [1:0]   s_mode = '0;
    logic         kb_start;
    logic [1:0]   kb_key_mode;
    logic [255:0] kb_key;
    logic         kb_key_ready = 1'b1;
    logic         busy, done, err;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        int           kind;
        int           cyc;
        logic [255:0] key;
        logic [1:0]   mode;
    } exp_t;
    exp_t sb[$];

    logic [31:0]  w [8];
    logic [255:0] model_key;

    aes_key_loader #(.WORD_W(32), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .resetH(resetH),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_mode(s_mode),
        .kb_start(kb_start), .kb_key_mode(kb_key_mode),
        .kb_key(kb_key), .kb_key_ready(kb_key_ready),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act,
                         input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int c,
                        input logic [255:0] key, input logic [1:0] mode);
        exp_t e;
        e.kind = kind; e.cyc = c; e.key = key; e.mode = mode;
        sb.push_back(e);
    endtask

    task automatic chk_ev(input int kind);
        exp_t e;
        if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d at cyc %0d expected none", kind, cyc);
        end else begin
            e = sb.pop_front();
            check("ev_kind", kind, e.kind);
            check("ev_cyc", cyc, e.cyc);
            if (kind == 0) begin
                check("kb_key", kb_key, e.key);
                check("kb_key_mode", {254'b0, kb_key_mode}, {254'b0, e.mode});
            end
        end
    endtask

    // kinds: 0 = kb_start, 1 = done, 2 = err
    always @(negedge clk) begin
        if (!resetH) begin
            if (kb_start) chk_ev(0);
            if (done)     chk_ev(1);
            if (err)      chk_ev(2);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic put_word(input logic [31:0] d, input logic [1:0] m);
        s_valid = 1'b1; s_data = d; s_mode = m;
        @(negedge clk);
        check("s_ready_accept", s_ready, 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0; s_data = '0; s_mode = '0;
    endtask

    function automatic logic [255:0] mk_key(input int n);
        logic [255:0] k = '0;
        for (int i = 0; i < n; i++) k[255 - 32*i -: 32] = w[i];
        return k;
    endfunction

    // Feed n words; first carries mode, later words carry junk mode 11.
    task automatic load(input int n, input logic [1:0] mode, input int gap);
        for (int i = 0; i < n; i++) begin
            put_word(w[i], (i == 0) ? mode : 2'b11);
            if (gap != 0 && i < n - 1) begin
                tick(i % 3);
                @(negedge clk);
                check("busy_gap", busy, 1);
                tick(1);
            end
        end
        model_key = mk_key(n);
        push(0, cyc, model_key, mode);
    endtask

    // Core drops ready then raises it; loader must hold s_ready low throughout.
    task automatic complete();
        @(negedge clk);
        check("s_ready_start", s_ready, 0);
        tick(1);
        kb_key_ready = 1'b0;
        @(negedge clk);
        check("s_ready_wait", s_ready, 0);
        tick(1);
        @(negedge clk);
        check("busy_wait", busy, 1);
        tick(1);
        kb_key_ready = 1'b1;
        push(1, cyc + 1, '0, 2'b00);
        tick(2);
        @(negedge clk);
        check("idle_after_done", {s_ready, busy}, 2'b10);
        tick(1);
    endtask

    task automatic chk_reset_state();
        @(negedge clk);
        check("rst_kb_key", kb_key, 0);
        check("rst_outs", {kb_key_mode, kb_start, done, err, busy, s_ready},
              7'b00_0000_1);
        tick(1);
    endtask

    initial begin
        tick(2);
        resetH = 1'b0;
        chk_reset_state();

        // 128-bit key
        for (int i = 0; i < 8; i++) w[i] = '0;
        w[0] = 32'h00010203; w[1] = 32'h04050607;
        w[2] = 32'h08090A0B; w[3] = 32'h0C0D0E0F;
        load(4, 2'b00, 0);
        check("key128_literal", model_key,
              {128'h000102030405060708090A0B0C0D0E0F, 128'h0});
        complete();

        // Illegal mode: dropped, err only, key untouched
        put_word(32'hDEADBEEF, 2'b11);
        push(2, cyc, '0, 2'b00);
        @(negedge clk);
        check("illegal_s_ready", s_ready, 1);
        check("illegal_key_kept", kb_key, model_key);
        check("illegal_busy", busy, 0);
        tick(2);

        // 256-bit key with s_valid gaps
        for (int i = 0; i < 8; i++) w[i] = 32'hA5000000 | (32'(i) << 8) | 32'(7 - i);
        load(8, 2'b10, 1);
        complete();

        // Timeout: ready falls and never returns
        for (int i = 0; i < 8; i++) w[i] = 32'h11111111 * (i + 1);
        load(4, 2'b00, 0);
        kb_key_ready = 1'b0;
        push(2, cyc + TMO, '0, 2'b00);
        tick(TMO + 4);
        @(negedge clk);
        check("tmo_idle", {s_ready, busy}, 2'b10);
        check("tmo_key_held", kb_key, model_key);
        tick(1);

        // Reset in the middle of a 192-bit load
        kb_key_ready = 1'b1;
        for (int i = 0; i < 8; i++) w[i] = 32'hC0DE0000 + 32'(i);
        for (int i = 0; i < 3; i++) put_word(w[i], 2'b01);
        resetH = 1'b1;
        tick(1);
        resetH = 1'b0;
        chk_reset_state();
        load(6, 2'b01, 0);
        check("key192_lsbs_zero", model_key[63:0], 0);
        complete();

        // Stale ready held high across start, drops two cycles later
        kb_key_ready = 1'b1;
        for (int i = 0; i < 8; i++) w[i] = 32'h5A5A0000 ^ (32'(i) << 16);
        load(4, 2'b00, 0);
        tick(2);
        kb_key_ready = 1'b0;
        tick(3);
        @(negedge clk);
        check("stale_busy", busy, 1);
        tick(1);
        kb_key_ready = 1'b1;
        push(1, cyc + 1, '0, 2'b00);
        tick(3);

        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1);
    end
endmodule
